// File: rtl/explo_shell_seq.sv
// Sound-control sequencer: turns CPU writes into timed shell/explosion enable
// windows with retrigger, hold-off and master sound-enable gating.
module explo_shell_seq #(
  parameter int unsigned SHELL_TICKS   = 48,
  parameter int unsigned EXPLO_TICKS   = 192,
  parameter int unsigned HOLDOFF_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_24KHz_en,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  output logic       sound_enable,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  typedef struct packed {
    state_e      st;
    logic [15:0] cnt;
    logic        pend;
    logic        pend_ls;
    logic        ls;
    logic        en;
  } chan_t;

  localparam logic [15:0] SHELL_W = 16'(SHELL_TICKS);
  localparam logic [15:0] EXPLO_W = 16'(EXPLO_TICKS);
  localparam logic [15:0] HOLD_W  = 16'(HOLDOFF_TICKS);

  logic [7:0] last_wr_q, last_wr_d;
  logic       sound_enable_q, sound_enable_d;
  logic       shell_trig, explo_trig;
  chan_t      sh_q, sh_d, ex_q, ex_d;
  logic       unused_bits;

  assign unused_bits = &{1'b0, cpu_data[7:6], cpu_data[4], last_wr_q[7:4], last_wr_q[1:0]};

  // One channel step. A trigger always outranks a coincident tick; in
  // hold-off the trigger only arms the pending restart, so the gap is never
  // shortened or stretched.
  function automatic chan_t chan_next(input chan_t       cur,
                                      input logic        trg,
                                      input logic        tls,
                                      input logic        tick,
                                      input logic        master_en,
                                      input logic [15:0] win);
    chan_t nx;
    nx = cur;
    if (!master_en) begin
      nx.st   = IDLE;
      nx.cnt  = '0;
      nx.pend = 1'b0;
    end else begin
      case (cur.st)
        IDLE: begin
          if (trg) begin
            nx.st  = ACTIVE;
            nx.cnt = win;
            nx.ls  = tls;
          end
        end
        ACTIVE: begin
          if (trg) begin
            nx.cnt = win;
            nx.ls  = tls;
          end else if (tick) begin
            if (cur.cnt == 16'd1) begin
              nx.st  = HOLDOFF;
              nx.cnt = HOLD_W;
            end else if (cur.cnt >= 16'd2) begin
              nx.cnt = cur.cnt - 16'd1;
            end
          end
        end
        HOLDOFF: begin
          if (trg) begin
            nx.pend    = 1'b1;
            nx.pend_ls = tls;
          end
          if (tick) begin
            if (cur.cnt == 16'd1) begin
              if (nx.pend) begin
                nx.st   = ACTIVE;
                nx.cnt  = win;
                nx.ls   = nx.pend_ls;
                nx.pend = 1'b0;
              end else begin
                nx.st  = IDLE;
                nx.cnt = '0;
              end
            end else if (cur.cnt >= 16'd2) begin
              nx.cnt = cur.cnt - 16'd1;
            end
          end
        end
        default: begin
          nx.st   = IDLE;
          nx.cnt  = '0;
          nx.pend = 1'b0;
        end
      endcase
    end
    nx.en = (nx.st == ACTIVE);
    return nx;
  endfunction

  // The D5 of the current write governs this very cycle, so a disabling
  // write kills both windows at the same edge that clears sound_enable.
  always_comb begin
    last_wr_d      = cpu_wr ? cpu_data    : last_wr_q;
    sound_enable_d = cpu_wr ? cpu_data[5] : sound_enable_q;
    shell_trig     = cpu_wr & cpu_data[5] & cpu_data[2] & ~last_wr_q[2];
    explo_trig     = cpu_wr & cpu_data[5] & cpu_data[3] & ~last_wr_q[3];
    sh_d = chan_next(sh_q, shell_trig, cpu_data[0], clk_24KHz_en, sound_enable_d, SHELL_W);
    ex_d = chan_next(ex_q, explo_trig, cpu_data[1], clk_24KHz_en, sound_enable_d, EXPLO_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_wr_q      <= '0;
      sound_enable_q <= 1'b0;
      sh_q           <= '0;
      ex_q           <= '0;
    end else begin
      last_wr_q      <= last_wr_d;
      sound_enable_q <= sound_enable_d;
      sh_q           <= sh_d;
      ex_q           <= ex_d;
    end
  end

  assign sound_enable = sound_enable_q;
  assign shell_en     = sh_q.en;
  assign shell_ls     = sh_q.ls;
  assign explo_en     = ex_q.en;
  assign explo_ls     = ex_q.ls;

endmodule

// File: tb/tb_explo_shell_seq.sv
// Scoreboard bench for explo_shell_seq: expected windows are queued as triggers
// are written and compared when each enable window closes.
module tb_explo_shell_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_24KHz_en;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       sound_enable, shell_en, shell_ls, explo_en, explo_ls;

  explo_shell_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_24KHz_en (clk_24KHz_en),
    .cpu_wr       (cpu_wr),
    .cpu_data     (cpu_data),
    .sound_enable (sound_enable),
    .shell_en     (shell_en),
    .shell_ls     (shell_ls),
    .explo_en     (explo_en),
    .explo_ls     (explo_ls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ticks;
    int ls;
  } win_t;

  win_t sh_q[$];
  win_t ex_q[$];
  int   sh_gap_q[$];
  win_t sh_w, ex_w;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Window monitor: counts ticks seen while each enable is high (and, for
  // shell, while low between windows) and scores them against the queues.
  logic sh_prev = 1'b0, ex_prev = 1'b0;
  int   sh_len = 0, sh_gap = 0, ex_len = 0;
  int   sh_ls_last = 0, ex_ls_last = 0;

  always @(negedge clk) begin
    if (shell_en === 1'b1) begin
      if (!sh_prev) begin
        sh_len = 0;
        if (sh_gap_q.size() > 0) chk("sh_gap", sh_gap, sh_gap_q.pop_front());
      end
      if (clk_24KHz_en) sh_len++;
      sh_ls_last = int'(shell_ls);
    end else begin
      if (sh_prev) begin
        chk("sh_win_expected", int'(sh_q.size() > 0), 1);
        if (sh_q.size() > 0) begin
          sh_w = sh_q.pop_front();
          chk("sh_win_len", sh_len, sh_w.ticks);
          chk("sh_win_ls", sh_ls_last, sh_w.ls);
        end
        sh_gap = 0;
      end
      if (clk_24KHz_en) sh_gap++;
    end
    sh_prev = (shell_en === 1'b1);

    if (explo_en === 1'b1) begin
      if (!ex_prev) ex_len = 0;
      if (clk_24KHz_en) ex_len++;
      ex_ls_last = int'(explo_ls);
    end else if (ex_prev) begin
      chk("ex_win_expected", int'(ex_q.size() > 0), 1);
      if (ex_q.size() > 0) begin
        ex_w = ex_q.pop_front();
        chk("ex_win_len", ex_len, ex_w.ticks);
        chk("ex_win_ls", ex_ls_last, ex_w.ls);
      end
    end
    ex_prev = (explo_en === 1'b1);
  end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic tk);
    cpu_wr       = wr;
    cpu_data     = d;
    clk_24KHz_en = tk;
    @(posedge clk);
    #1;
    cpu_wr       = 1'b0;
    cpu_data     = 8'h00;
    clk_24KHz_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_se"},     int'(sound_enable), 0);
    chk({tag, "_sh_en"},  int'(shell_en), 0);
    chk({tag, "_sh_ls"},  int'(shell_ls), 0);
    chk({tag, "_ex_en"},  int'(explo_en), 0);
    chk({tag, "_ex_ls"},  int'(explo_ls), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    cpu_wr       = 1'b0;
    cpu_data     = 8'h00;
    clk_24KHz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);

    // Basic shell window, soft, explo untouched; rewriting 1 is not a trigger
    sh_q.push_back('{48, 0});
    wr(8'h24);
    chk("basic_se", int'(sound_enable), 1);
    chk("basic_sh_en", int'(shell_en), 1);
    chk("basic_sh_ls", int'(shell_ls), 0);
    run(47);
    chk("basic_sh_on47", int'(shell_en), 1);
    run(13);
    chk("basic_sh_off", int'(shell_en), 0);
    chk("basic_ex_off", int'(explo_en), 0);
    wr(8'h24);
    run(20);
    chk("rewrite_no_win", int'(shell_en), 0);

    // Hold-off with a pending loud trigger 5 ticks in
    sh_q.push_back('{48, 0});
    wr(8'h20);
    wr(8'h24);
    run(48);
    chk("hold_win_end", int'(shell_en), 0);
    run(5);
    sh_gap_q.push_back(16);
    sh_q.push_back('{48, 1});
    wr(8'h20);
    wr(8'h25);
    chk("hold_pend_low", int'(shell_en), 0);
    run(10);
    chk("hold_still_low", int'(shell_en), 0);
    run(1);
    chk("hold_restart", int'(shell_en), 1);
    chk("hold_restart_ls", int'(shell_ls), 1);
    run(48);
    chk("hold_win2_end", int'(shell_en), 0);
    run(20);

    // Explo retrigger mid-window relatches loud and reloads the full count
    ex_q.push_back('{292, 1});
    wr(8'h28);
    chk("retrig_start", int'(explo_en), 1);
    chk("retrig_ls0", int'(explo_ls), 0);
    run(100);
    wr(8'h20);
    wr(8'h2A);
    chk("retrig_en", int'(explo_en), 1);
    chk("retrig_ls1", int'(explo_ls), 1);
    run(191);
    chk("retrig_on191", int'(explo_en), 1);
    run(1);
    chk("retrig_off", int'(explo_en), 0);
    run(20);

    // Master disable mid-window; ls holds; disabled triggers are ignored
    ex_q.push_back('{30, 1});
    wr(8'h20);
    wr(8'h2A);
    run(30);
    wr(8'h08);
    chk("dis_se", int'(sound_enable), 0);
    chk("dis_ex_en", int'(explo_en), 0);
    chk("dis_ex_ls_hold", int'(explo_ls), 1);
    wr(8'h00);
    wr(8'h08);
    run(10);
    chk("dis_no_win_ex", int'(explo_en), 0);
    chk("dis_no_win_sh", int'(shell_en), 0);
    chk("dis_se_still0", int'(sound_enable), 0);

    // Retrigger coincident with a tick: the tick is not a decrement
    sh_q.push_back('{59, 0});
    wr(8'h24);
    chk("coin_se", int'(sound_enable), 1);
    chk("coin_sh_en", int'(shell_en), 1);
    run(10);
    wr(8'h20);
    cyc(1'b1, 8'h24, 1'b1);
    chk("coin_sh_on", int'(shell_en), 1);
    run(47);
    chk("coin_on47", int'(shell_en), 1);
    run(1);
    chk("coin_off", int'(shell_en), 0);
    run(20);

    // Asynchronous reset mid-window, then both windows from one write
    ex_q.push_back('{20, 1});
    wr(8'h20);
    wr(8'h2A);
    run(20);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    sh_q.push_back('{48, 0});
    ex_q.push_back('{192, 0});
    wr(8'h2C);
    chk("post_rst_se", int'(sound_enable), 1);
    chk("post_rst_sh_en", int'(shell_en), 1);
    chk("post_rst_ex_en", int'(explo_en), 1);
    run(200);
    chk("post_rst_sh_off", int'(shell_en), 0);
    chk("post_rst_ex_off", int'(explo_en), 0);

    chk("sh_q_drained", sh_q.size(), 0);
    chk("ex_q_drained", ex_q.size(), 0);
    chk("gap_q_drained", sh_gap_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/explo_shell_seq.md
# explo_shell_seq

Sequencer for the shell and explosion noise channels. Captures CPU writes to the sound control register and converts trigger bits into timed enable windows with retrigger and hold-off rules. It also latches the loud/soft selects and gates everything on the master sound enable. Its outputs drive the `shell_en/shell_ls/explo_en/explo_ls/sound_enable` inputs of the noise source shell.

## Interface
- `SHELL_TICKS`, 48: shell enable window length, in `clk_24KHz_en` ticks (2 ms); legal 1..65535.
- `EXPLO_TICKS`, 192: explosion enable window length, in ticks (8 ms); legal 1..65535.
- `HOLDOFF_TICKS`, 16: minimum enable-low gap after a window before a new one may start; legal 1..65535.

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_24KHz_en`  in  1  one-`clk` tick strobe at 24 kHz.
- `cpu_wr`  in  1  one-cycle write strobe to the sound control register.
- `cpu_data`  in  8  write data:
  - D0 = shell loud/soft
  - D1 = explo loud/soft
  - D2 = shell trigger
  - D3 = explo trigger
  - D5 = sound enable
  - other bits ignored.
- `sound_enable`  out  1  registered D5.
- `shell_en`  out  1  shell channel enable window.
- `shell_ls`  out  1  shell loud/soft, latched at window start.
- `explo_en`  out  1  explo channel enable window.
- `explo_ls`  out  1  explo loud/soft, latched at window start.

## Operation
- **Register capture:** on `cpu_wr`, `cpu_data` is stored in `last_wr[7:0]`; `sound_enable` <= D5.
- **Trigger detection:** a trigger occurs when `cpu_wr` is high and D2 (shell) or D3 (explo) is 1 while the same bit in `last_wr` is 0 (rising edge between writes). Rewriting 1 is not a trigger.
- **Sound enable gating:** triggers are evaluated only if D5 of the same write is 1; D5 takes effect first.
- **Channel FSMs:** two identical channels (shell, explo), each with a 16-bit counter `cnt` and a `pending` flag.
  - IDLE: en=0. A trigger goes to ACTIVE with `cnt`=TICKS and ls latched from D0 (shell) or D1 (explo).
  - ACTIVE: en=1. On a tick, `cnt`-=1; when a tick arrives with `cnt`==1, go to HOLDOFF with `cnt`=HOLDOFF_TICKS. A trigger reloads `cnt`=TICKS and relatches ls; it stays ACTIVE and en stays high.
  - HOLDOFF: en=0. A trigger sets `pending`=1 and records ls in `pending_ls`. On a tick with `cnt`==1: if `pending`, go to ACTIVE with `cnt`=TICKS, ls=`pending_ls`, `pending`=0; otherwise go to IDLE.
- **Simultaneous events:**
  - Trigger and tick in the same cycle: the trigger wins (reload, no decrement).
  - Triggers on both channels in one write: handled independently.
- **Master disable:** `sound_enable`=0 (after a write with D5=0) forces both channels to IDLE and clears `cnt`, `pending` and en. ls outputs hold their last value.
- **Arithmetic:** `cnt` never wraps; decrement occurs only when `cnt` >= 2.

## Timing
- **Reset values:** all outputs 0, `last_wr`=0, both channels IDLE, `cnt`=0, `pending`=0.
- **Trigger latency:** a trigger write in cycle T gives en=1 and ls valid at the clk edge ending T, i.e. visible in T+1.
- **`sound_enable` latency:** 1 cycle after `cpu_wr`. The forced-off takes effect in that same cycle: en falls in T+1.
- **Window length:** en is high for exactly TICKS tick strobes after entry. Ticks in the entry cycle do not count. en falls in the cycle after the TICKS-th tick.
- **Hold-off length:** en is low for at least HOLDOFF_TICKS ticks between windows.
- **Mid-operation reset:** `reset_n` low at any point clears state immediately (asynchronous); release is synchronous to `clk`.

## Test plan
- **Basic window:** reset, write 0x24 (D5, D2), then 60 ticks. Required: `shell_en` high for exactly 48 ticks, `shell_ls`=0, `explo_en` stays 0; writing 0x24 again produces no new window.
- **Retrigger:** write 0x28 (D5, D3); after 100 ticks write 0x20 then 0x2A. Required: `explo_en` stays continuously high and falls 192 ticks after the second trigger; `explo_ls` changes to 1 at the retrigger.
- **Hold-off pending:** shell window ends; trigger 5 ticks into hold-off with D0=1. Required: `shell_en` low for exactly 16 ticks, then high for 48 ticks with `shell_ls`=1.
- **Disable mid-window:** during an explo window, write 0x08 (D5=0). Required: `sound_enable` and `explo_en` are 0 in the next cycle; a later 0x08→0x00→0x08 write sequence causes no window.
- **Simultaneous events and reset:** trigger coincident with a tick reloads the full count. Asserting `reset_n` low mid-window drives all outputs 0 in the same cycle; after release, the first write of 0x2C starts both windows.
